// File: rtl/vred_sequencer.sv
// ---------------------------------------------------------------------------
// vred_sequencer
//
// Sequencer between the vector issue stage and the reduction sum/min/max
// unit. One request (word count, element width, operation, scalar seed) is
// accepted at a time. The sequencer then drives the unit with one dependent
// operation at a time:
//   1. lane-wise accumulation of every packed element word,
//   2. intra-word folding (halve the live width each step) down to one
//      element,
//   3. a final combine with the scalar seed (skipped only when vl = 0).
// The low SEW bits of the final accumulator are returned as the response.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   req_*             request handshake and fields (vl, sew, opSel, scalar)
//   elem_*            packed element word stream into the sequencer
//   unit_vec0         operand pair to the unit, {B, A} with A in the low half
//   unit_en           one-cycle issue strobe to the unit
//   unit_sew/opSel    latched request element width and operation
//   unit_out          unit result, valid UNIT_LATENCY cycles after issue
//   resp_*            response handshake; resp_data is masked to SEW bits
//   busy              high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module vred_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int VL_WIDTH     = 8,
  parameter int SEW_WIDTH    = 2,
  parameter int OPSEL_WIDTH  = 2,
  parameter int UNIT_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [VL_WIDTH-1:0]     req_vl,
  input  logic [SEW_WIDTH-1:0]    req_sew,
  input  logic [OPSEL_WIDTH-1:0]  req_opSel,
  input  logic [DATA_WIDTH-1:0]   req_scalar,
  input  logic                    elem_valid,
  output logic                    elem_ready,
  input  logic [DATA_WIDTH-1:0]   elem_data,
  output logic [2*DATA_WIDTH-1:0] unit_vec0,
  output logic                    unit_en,
  output logic [SEW_WIDTH-1:0]    unit_sew,
  output logic [OPSEL_WIDTH-1:0]  unit_opSel,
  input  logic [DATA_WIDTH-1:0]   unit_out,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam int LOG2_DW = $clog2(DATA_WIDTH);
  localparam int FW_W    = LOG2_DW + 1;
  localparam int CNT_W   = (UNIT_LATENCY > 1) ? $clog2(UNIT_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_LATENCY - 1);

  logic [2:0]              state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   scalar_q, scalar_d;
  logic [VL_WIDTH-1:0]     vl_q, vl_d;
  logic [VL_WIDTH-1:0]     remaining_q, remaining_d;
  logic [SEW_WIDTH-1:0]    sew_q, sew_d;
  logic [OPSEL_WIDTH-1:0]  opsel_q, opsel_d;
  logic [3:0]              p_q, p_d;
  logic [FW_W-1:0]         fold_w_q, fold_w_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    seed_done_q, seed_done_d;
  logic [2*DATA_WIDTH-1:0] vec_q, vec_d;

  logic [3:0]              p_init;
  logic [DATA_WIDTH-1:0]   fold_b;
  logic [7:0]              sew_bits;
  logic [DATA_WIDTH-1:0]   sew_mask;

  // Number of fold steps = log2(DATA_WIDTH / element bits); element bits are
  // 8 << sew, so this is LOG2_DW - 3 - sew, clamped at zero.
  always_comb begin
    p_init = '0;
    if (int'(req_sew) + 3 < LOG2_DW) begin
      p_init = 4'(LOG2_DW - 3 - int'(req_sew));
    end
  end

  // The fold partner is the upper half of the still-live width of acc.
  assign fold_b = acc_q >> (fold_w_q >> 1);

  // Result mask keeps only the low SEW bits of the accumulator.
  always_comb begin
    sew_bits = 8'd8 << sew_q;
    sew_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sew_mask[i] = (i < int'(sew_bits));
    end
  end

  // Next-state logic. unit_en is combinational in ISSUE because the
  // accumulate operand comes straight from elem_data in the same cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    scalar_d    = scalar_q;
    vl_d        = vl_q;
    remaining_d = remaining_q;
    sew_d       = sew_q;
    opsel_d     = opsel_q;
    p_d         = p_q;
    fold_w_d    = fold_w_q;
    wait_cnt_d  = wait_cnt_q;
    seed_done_d = seed_done_q;
    vec_d       = vec_q;
    unit_en     = 1'b0;
    elem_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          vl_d        = req_vl;
          sew_d       = req_sew;
          opsel_d     = req_opSel;
          scalar_d    = req_scalar;
          p_d         = p_init;
          fold_w_d    = FW_W'(DATA_WIDTH);
          wait_cnt_d  = '0;
          seed_done_d = 1'b0;
          if (req_vl == '0) begin
            acc_d   = req_scalar;
            state_d = S_RESP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        elem_ready = 1'b1;
        if (elem_valid) begin
          acc_d       = elem_data;
          remaining_d = vl_q - VL_WIDTH'(1);
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (remaining_q != '0) begin
          // Accumulate stalls with unit_en low until a word arrives.
          elem_ready = 1'b1;
          if (elem_valid) begin
            unit_en     = 1'b1;
            vec_d       = {elem_data, acc_q};
            remaining_d = remaining_q - VL_WIDTH'(1);
            state_d     = S_WAIT;
          end
        end else if (p_q != '0) begin
          unit_en  = 1'b1;
          vec_d    = {fold_b, acc_q};
          p_d      = p_q - 4'd1;
          fold_w_d = fold_w_q >> 1;
          state_d  = S_WAIT;
        end else if (!seed_done_q) begin
          unit_en     = 1'b1;
          vec_d       = {scalar_q, acc_q};
          seed_done_d = 1'b1;
          state_d     = S_WAIT;
        end else begin
          state_d = S_RESP;
        end
      end

      S_WAIT: begin
        if (wait_cnt_q == CNT_LAST) begin
          acc_d      = unit_out;
          wait_cnt_d = '0;
          state_d    = S_ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight operation outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      scalar_q    <= '0;
      vl_q        <= '0;
      remaining_q <= '0;
      sew_q       <= '0;
      opsel_q     <= '0;
      p_q         <= '0;
      fold_w_q    <= '0;
      wait_cnt_q  <= '0;
      seed_done_q <= 1'b0;
      vec_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      scalar_q    <= scalar_d;
      vl_q        <= vl_d;
      remaining_q <= remaining_d;
      sew_q       <= sew_d;
      opsel_q     <= opsel_d;
      p_q         <= p_d;
      fold_w_q    <= fold_w_d;
      wait_cnt_q  <= wait_cnt_d;
      seed_done_q <= seed_done_d;
      vec_q       <= vec_d;
    end
  end

  // Operands show the new pair on an issue cycle and hold otherwise.
  assign unit_vec0  = vec_d;
  assign unit_sew   = sew_q;
  assign unit_opSel = opsel_q;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_data  = resp_valid ? (acc_q & sew_mask) : '0;

endmodule
